// File: rtl/memory_pkg.sv
// Shared memory-side types and sizing helpers for the data-cache write buffer.
package memory_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF    = 128;

  typedef struct packed {
    logic [ADDRESS_WIDTH_DEF-1:0] address;
    logic [DATA_WIDTH_DEF-1:0]    data;
  } wb_entry_t;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_lookup.sv
// Youngest-first address match across the write buffer entries.
// Only built when WB_FORWARD_EN is defined.
`ifdef WB_FORWARD_EN
module wb_lookup
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 128,
  parameter int unsigned PTR_W         = ptr_width(DEPTH)
) (
  input  logic [ADDRESS_WIDTH-1:0] mem_address [DEPTH],
  input  logic [DATA_WIDTH-1:0]    mem_data    [DEPTH],
  input  logic [DEPTH-1:0]         valid,
  input  logic [PTR_W-1:0]         rd_ptr,
  input  logic [PTR_W-1:0]         wr_ptr,
  input  logic [ADDRESS_WIDTH-1:0] lk_address,
  output logic                     hit,
  output logic [DATA_WIDTH-1:0]    data
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit = hit | (valid[i] && (mem_address[i] == lk_address));
    end
  end

  // Walk backwards from the newest entry; the oldest entry (rd_ptr) ends the scan.
  always_comb begin
    logic             done;
    logic [PTR_W-1:0] idx;
    data = '0;
    done = 1'b0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = wr_ptr - PTR_W'(1) - PTR_W'(i);
      if (!done && valid[idx] && (mem_address[idx] == lk_address)) begin
        data = mem_data[idx];
        done = 1'b1;
      end
      if (idx == rd_ptr) begin
        done = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/write_buffer_fifo.sv
// Circular address+data write buffer, first-word-fall-through, valid/ready on both sides.
// Define WB_FORWARD_EN to add the youngest-match address lookup port.
module write_buffer_fifo
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 128,
  parameter int unsigned AF_LEVEL      = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDRESS_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ADDRESS_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDRESS_WIDTH-1:0] lk_address,
  output logic                     lk_hit,
  output logic [DATA_WIDTH-1:0]    lk_data
`endif
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDRESS_WIDTH-1:0] mem_address [DEPTH];
  logic [DATA_WIDTH-1:0]    mem_data    [DEPTH];

  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;
  logic            push;
  logic            pop;

  // Status is decoded purely from the registered count.
  assign full        = (count_q == CntW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CntW'(AF_LEVEL));
  assign count       = count_q;

  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  assign rd_address = empty ? '0 : mem_address[rd_ptr_q];
  assign rd_data    = empty ? '0 : mem_data[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_address[wr_ptr_q] <= wr_address;
      mem_data[wr_ptr_q]    <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

`ifdef WB_FORWARD_EN
  logic [DEPTH-1:0] valid_q;

  // wr_ptr and rd_ptr never coincide when push and pop fire together, so no conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (push) valid_q[wr_ptr_q] <= 1'b1;
      if (pop)  valid_q[rd_ptr_q] <= 1'b0;
    end
  end

  wb_lookup #(
    .DEPTH        (DEPTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .PTR_W        (PtrW)
  ) u_lookup (
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .valid      (valid_q),
    .rd_ptr     (rd_ptr_q),
    .wr_ptr     (wr_ptr_q),
    .lk_address (lk_address),
    .hit        (lk_hit),
    .data       (lk_data)
  );
`endif

endmodule

// File: tb/tb_write_buffer_fifo.sv
// Directed bench for write_buffer_fifo with a queue scoreboard; forward checks under WB_FORWARD_EN.
module tb_write_buffer_fifo;
  import memory_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_address = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] rd_data;
  logic [2:0]    count;
  logic          full;
  logic          empty;
  logic          almost_full;
`ifdef WB_FORWARD_EN
  logic [AW-1:0] lk_address = '0;
  logic          lk_hit;
  logic [DW-1:0] lk_data;
`endif

  int checks = 0;
  int errors = 0;
  int m_count = 0;
  wb_entry_t sb[$];

  always #5 clk = ~clk;

  write_buffer_fifo #(
    .DEPTH        (DEPTH),
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .AF_LEVEL     (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_address (rd_address),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full)
`ifdef WB_FORWARD_EN
    ,
    .lk_address (lk_address),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data)
`endif
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    check("count", DW'(count), DW'(m_count));
    check("full", DW'(full), DW'(m_count == DEPTH));
    check("empty", DW'(empty), DW'(m_count == 0));
    check("almost_full", DW'(almost_full), DW'(m_count >= 3));
    check("wr_ready", DW'(wr_ready), DW'(m_count != DEPTH));
    check("rd_valid", DW'(rd_valid), DW'(m_count != 0));
    if (m_count != 0) begin
      check("head_addr", DW'(rd_address), DW'(sb[0].address));
      check("head_data", rd_data, sb[0].data);
    end else begin
      check("head_addr_zero", DW'(rd_address), '0);
      check("head_data_zero", rd_data, '0);
    end
  endtask

  // Called just after a rising edge: drive, compare popped head, clock, then check state.
  task automatic cycle(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rr);
    bit pa;
    bit pp;
    wb_entry_t e;
    wr_valid   = wv;
    wr_address = wa;
    wr_data    = wd;
    rd_ready   = rr;
    pa = wv && (m_count < DEPTH);
    pp = rr && (m_count != 0);
    check("rd_valid_pre", DW'(rd_valid), DW'(m_count != 0));
    if (pp) begin
      check("pop_addr", DW'(rd_address), DW'(sb[0].address));
      check("pop_data", rd_data, sb[0].data);
      void'(sb.pop_front());
    end
    if (pa) begin
      e.address = wa;
      e.data    = wd;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    m_count = m_count + (pa ? 1 : 0) - (pp ? 1 : 0);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check_status();
  endtask

  initial begin
    // Reset state
    #12;
    check_status();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, then a dropped fifth push
    for (int k = 1; k <= 4; k++) cycle(1'b1, AW'(32'h100 * k), DW'(k), 1'b0);
    cycle(1'b1, 32'h500, DW'(5), 1'b0);
    check("head_after_drop", DW'(rd_address), DW'(32'h100));

    // Drain in order, then rd_ready while empty
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);

    // Push into empty: not visible in the push cycle, visible after
    cycle(1'b1, 32'hABC, DW'(128'h55), 1'b0);
    cycle(1'b1, 32'hABD, DW'(128'h66), 1'b0);

    // Streaming at count 2 with both handshakes high
    for (int i = 0; i < 10; i++) cycle(1'b1, AW'(32'h1000 + i), DW'(128'hD00 + i), 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);

    // Asynchronous reset at count 3, between clock edges
    for (int k = 0; k < 3; k++) cycle(1'b1, AW'(32'h2000 + k), DW'(k + 7), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_count = 0;
    check_status();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h3000, DW'(128'hBEEF), 1'b0);
    cycle(1'b0, '0, '0, 1'b1);

`ifdef WB_FORWARD_EN
    cycle(1'b1, 32'h100, DW'(128'hA), 1'b0);
    lk_address = 32'h100;
    #1;
    check("lk_hit_same_cycle", DW'(lk_hit), DW'(1));
    check("lk_data_same_cycle", lk_data, DW'(128'hA));
    cycle(1'b1, 32'h100, DW'(128'hB), 1'b0);
    lk_address = 32'h100;
    #1;
    check("lk_hit_match", DW'(lk_hit), DW'(1));
    check("lk_data_youngest", lk_data, DW'(128'hB));
    lk_address = 32'h200;
    #1;
    check("lk_hit_miss", DW'(lk_hit), DW'(0));
    check("lk_data_miss", lk_data, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
